// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core.
// Opcodes, functs, FSM states, datapath selects and the ALU.
package mc_cpu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_SLT, ALU_SLL
  } alu_op_t;

  typedef enum logic [1:0] {
    B_REG, B_FOUR, B_IMM, B_IMM4
  } alu_b_t;

  typedef enum logic [1:0] {
    PC_ALU, PC_OUT, PC_JMP, PC_A
  } pc_sel_t;

  typedef enum logic [1:0] {
    DST_RT, DST_RD, DST_RA
  } dst_t;

  typedef enum logic [1:0] {
    WD_ALU, WD_MDR, WD_PC
  } wd_t;

  function automatic logic [31:0] alu(
    input alu_op_t     op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  sh
  );
    logic [31:0] y;
    y = a + b;
    unique case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: y = b << sh;
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mc_cpu_ctrl.sv
// FSM and instruction decode for the multi-cycle core.
// Drives every datapath enable/select and the memory strobes.
module mc_cpu_ctrl
  import mc_cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] i_op,
  input  logic [5:0] i_fn,
  input  logic       i_mem_ready,
  input  logic       i_a_eq_b,
  output state_t     o_state,
  output alu_op_t    o_alu_op,
  output logic       o_alu_a_pc,
  output alu_b_t     o_alu_b,
  output logic       o_pc_we,
  output pc_sel_t    o_pc_sel,
  output logic       o_ir_we,
  output logic       o_mdr_we,
  output logic       o_rf_we,
  output dst_t       o_rf_dst,
  output wd_t        o_rf_wd,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_halt
);

  state_t  r_state;
  state_t  w_next;
  logic    w_legal;
  alu_op_t w_r_op;

  assign o_state = r_state;

  always_comb begin
    w_legal = 1'b0;
    case (i_op)
      OP_R: w_legal = i_fn inside
        {FN_ADD, FN_SUB, FN_AND, FN_OR,
         FN_SLT, FN_SLL, FN_JR};
      OP_ADDI, OP_LW, OP_SW,
      OP_BEQ, OP_J, OP_JAL: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_r_op = ALU_ADD;
    case (i_fn)
      FN_SUB:  w_r_op = ALU_SUB;
      FN_AND:  w_r_op = ALU_AND;
      FN_OR:   w_r_op = ALU_OR;
      FN_SLT:  w_r_op = ALU_SLT;
      FN_SLL:  w_r_op = ALU_SLL;
      default: w_r_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_alu_op   = ALU_ADD;
    o_alu_a_pc = 1'b0;
    o_alu_b    = B_REG;
    o_pc_we    = 1'b0;
    o_pc_sel   = PC_ALU;
    o_ir_we    = 1'b0;
    o_mdr_we   = 1'b0;
    o_rf_we    = 1'b0;
    o_rf_dst   = DST_RT;
    o_rf_wd    = WD_ALU;
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    o_halt     = 1'b0;
    unique case (r_state)
      S_IF: begin
        o_mem_req  = 1'b1;
        o_alu_a_pc = 1'b1;
        o_alu_b    = B_FOUR;
        if (i_mem_ready) begin
          o_ir_we = 1'b1;
          o_pc_we = 1'b1;
          w_next  = S_ID;
        end
      end
      S_ID: begin
        o_alu_a_pc = 1'b1;
        o_alu_b    = B_IMM4;
        w_next     = w_legal ? S_EX : S_HALT;
      end
      S_EX: begin
        w_next = S_IF;
        case (i_op)
          OP_R: begin
            if (i_fn == FN_JR) begin
              o_pc_we  = 1'b1;
              o_pc_sel = PC_A;
            end else begin
              o_alu_op = w_r_op;
              w_next   = S_WB;
            end
          end
          OP_ADDI: begin
            o_alu_b = B_IMM;
            w_next  = S_WB;
          end
          OP_LW, OP_SW: begin
            o_alu_b = B_IMM;
            w_next  = S_MEM;
          end
          OP_BEQ: begin
            o_pc_we  = i_a_eq_b;
            o_pc_sel = PC_OUT;
          end
          OP_J: begin
            o_pc_we  = 1'b1;
            o_pc_sel = PC_JMP;
          end
          OP_JAL: begin
            o_pc_we  = 1'b1;
            o_pc_sel = PC_JMP;
            o_rf_we  = 1'b1;
            o_rf_dst = DST_RA;
            o_rf_wd  = WD_PC;
          end
          default: w_next = S_HALT;
        endcase
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (i_op == OP_SW);
        if (i_mem_ready) begin
          o_mdr_we = (i_op != OP_SW);
          w_next   = (i_op == OP_SW) ? S_IF : S_WB;
        end
      end
      S_WB: begin
        o_rf_we  = 1'b1;
        o_rf_dst = (i_op == OP_R) ? DST_RD : DST_RT;
        o_rf_wd  = (i_op == OP_LW) ? WD_MDR : WD_ALU;
        w_next   = S_IF;
      end
      S_HALT: o_halt = 1'b1;
      default: w_next = S_HALT;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core with one shared ALU and
// a single req/ready memory port for fetch and data.
module multi_cycle_cpu
  import mc_cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              halt_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_aluout;
  logic [31:0]       r_mdr;
  logic [31:0]       r_rf [32];

  state_t  w_state;
  alu_op_t w_alu_op;
  alu_b_t  w_alu_b_sel;
  pc_sel_t w_pc_sel;
  dst_t    w_rf_dst;
  wd_t     w_rf_wd;
  logic    w_alu_a_pc;
  logic    w_pc_we;
  logic    w_ir_we;
  logic    w_mdr_we;
  logic    w_rf_we;
  logic    w_mem_req;
  logic    w_mem_we;
  logic    w_halt;

  logic [31:0]       w_pc32;
  logic [31:0]       w_sext;
  logic [31:0]       w_jmp32;
  logic [31:0]       w_alu_a;
  logic [31:0]       w_alu_b;
  logic [31:0]       w_alu_y;
  logic [31:0]       w_rs_val;
  logic [31:0]       w_rt_val;
  logic [31:0]       w_wdata;
  logic [4:0]        w_waddr;
  logic [ADDR_W-1:0] w_pc_nxt;

  mc_cpu_ctrl u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_op        (r_ir[31:26]),
    .i_fn        (r_ir[5:0]),
    .i_mem_ready (mem_ready_i),
    .i_a_eq_b    (r_a == r_b),
    .o_state     (w_state),
    .o_alu_op    (w_alu_op),
    .o_alu_a_pc  (w_alu_a_pc),
    .o_alu_b     (w_alu_b_sel),
    .o_pc_we     (w_pc_we),
    .o_pc_sel    (w_pc_sel),
    .o_ir_we     (w_ir_we),
    .o_mdr_we    (w_mdr_we),
    .o_rf_we     (w_rf_we),
    .o_rf_dst    (w_rf_dst),
    .o_rf_wd     (w_rf_wd),
    .o_mem_req   (w_mem_req),
    .o_mem_we    (w_mem_we),
    .o_halt      (w_halt)
  );

  assign w_pc32   = 32'(r_pc);
  assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_jmp32  = {w_pc32[31:28], r_ir[25:0], 2'b00};
  assign w_rs_val = r_rf[r_ir[25:21]];
  assign w_rt_val = r_rf[r_ir[20:16]];
  assign w_alu_a  = w_alu_a_pc ? w_pc32 : r_a;

  always_comb begin
    w_alu_b = r_b;
    unique case (w_alu_b_sel)
      B_FOUR:  w_alu_b = 32'd4;
      B_IMM:   w_alu_b = w_sext;
      B_IMM4:  w_alu_b = w_sext << 2;
      default: w_alu_b = r_b;
    endcase
  end

  assign w_alu_y = alu(w_alu_op, w_alu_a, w_alu_b, r_ir[10:6]);

  always_comb begin
    w_pc_nxt = w_alu_y[ADDR_W-1:0];
    unique case (w_pc_sel)
      PC_OUT:  w_pc_nxt = r_aluout[ADDR_W-1:0];
      PC_JMP:  w_pc_nxt = w_jmp32[ADDR_W-1:0];
      PC_A:    w_pc_nxt = r_a[ADDR_W-1:0];
      default: w_pc_nxt = w_alu_y[ADDR_W-1:0];
    endcase
  end

  always_comb begin
    w_waddr = r_ir[20:16];
    w_wdata = r_aluout;
    unique case (w_rf_dst)
      DST_RD:  w_waddr = r_ir[15:11];
      DST_RA:  w_waddr = 5'd31;
      default: w_waddr = r_ir[20:16];
    endcase
    unique case (w_rf_wd)
      WD_MDR:  w_wdata = r_mdr;
      WD_PC:   w_wdata = w_pc32;
      default: w_wdata = r_aluout;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      if (w_ir_we)  r_ir  <= mem_rdata_i;
      if (w_pc_we)  r_pc  <= w_pc_nxt;
      if (w_mdr_we) r_mdr <= mem_rdata_i;
      if (w_state == S_ID) begin
        r_a <= w_rs_val;
        r_b <= w_rt_val;
      end
      if (w_state == S_ID || w_state == S_EX)
        r_aluout <= w_alu_y;
    end
  end

  // $0 is never written, so it always reads back as zero
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_rf_we && w_waddr != 5'd0) begin
      r_rf[w_waddr] <= w_wdata;
    end
  end

  // reset masks the bus combinationally so a live transfer drops at once
  assign mem_req_o   = rst_i & w_mem_req;
  assign mem_we_o    = rst_i & w_mem_we;
  assign halt_o      = rst_i & w_halt;
  assign mem_wdata_o = rst_i ? r_b : 32'd0;
  assign mem_addr_o  = !rst_i ? '0 :
                       (w_state == S_MEM) ?
                       r_aluout[ADDR_W-1:0] : r_pc;
  assign pc_o        = r_pc;

endmodule

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
- Multi-cycle MIPS-subset core; successor to the single-cycle CPU.
- One shared ALU and one unified memory port.
- Memory access uses a req/ready handshake, so memory may take any number of wait states.
- PC reset value and address width are parametrised.
- Adds a HALT state on illegal opcodes.
- Sits between the testbench/top level and an external unified instruction/data memory.

Parameters:
- ADDR_W, 32: width of mem_addr_o and pc_o; PC arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset; must be word aligned.

Ports:
- clk_i, input, 1: clock; all state changes on the rising edge.
- rst_i, input, 1: reset.
- mem_req_o, output, 1: memory request, held until accepted.
- mem_we_o, output, 1: 1 = write (sw), 0 = read.
- mem_addr_o, output, ADDR_W: byte address; stable while mem_req_o is high.
- mem_wdata_o, output, 32: store data; valid when mem_we_o is high.
- mem_rdata_i, input, 32: read data; sampled on the edge where mem_ready_i is high.
- mem_ready_i, input, 1: transfer completes at an edge where mem_req_o and mem_ready_i are both high.
- halt_o, output, 1: core stopped on an illegal opcode.
- pc_o, output, ADDR_W: current PC, for debug.

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-low (rst_i).
- While rst_i=0: PC=RESET_PC, state=IF, all 32 registers=0, IR/A/B/ALUOut/MDR=0.
- While rst_i=0, mem_req_o, mem_we_o and halt_o are forced to 0 and mem_addr_o/mem_wdata_o are 0.
- Reset asserted mid-transfer abandons the transfer immediately; memory must tolerate req dropping.
- Register $0 always reads 0; writes to it are discarded.
- Instruction 0x00000000 is a nop (sll $0), costing 4 cycles.
- State IF:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=PC.
  - On the accept edge: IR<=mem_rdata_i, PC<=PC+4, go to ID.
  - Otherwise stay in IF.
- State ID:
  - A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2).
  - Decode; an illegal opcode or funct goes to HALT, otherwise to EX.
- State EX:
  - R-type add/sub/and/or/slt/sll: ALUOut<=result, go to WB.
  - addi: ALUOut<=A+sext(imm), go to WB.
  - lw/sw: ALUOut<=A+sext(imm), go to MEM.
  - beq: if A==B then PC<=ALUOut; go to IF.
  - j: PC<={PC[ADDR_W-1:28], IR[25:0], 2'b00}; go to IF.
  - jal: $31<=PC (already PC+4); PC<=jump target; go to IF.
  - jr (funct 001000): PC<=A; go to IF; no register write.
- State MEM:
  - mem_req_o=1, mem_addr_o=ALUOut, mem_we_o=(sw), mem_wdata_o=B.
  - On accept: lw latches MDR and goes to WB; sw goes to IF.
- State WB:
  - Destination is rd for R-type, rt for addi/lw.
  - Data is ALUOut, or MDR for lw.
  - Go to IF.
- State HALT:
  - halt_o=1, mem_req_o=0, PC frozen.
  - Left only by reset.
- ALU details:
  - 32-bit two's complement arithmetic; overflow is ignored and wraps.
  - slt is a signed compare.
  - sll uses shamt IR[10:6].
- Cycle counts with zero wait states (mem_ready_i tied high): beq/j/jal/jr 3; R-type/addi/sw 4; lw 5.
- Each wait cycle adds one cycle in IF or MEM.
- Unaligned addresses are passed through unchanged; no exception is raised.

Decomposition:
- Package mc_cpu_pkg:
  - opcode constants: R=000000, addi=001000, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
  - funct constants: add=100000, sub=100010, and=100100, or=100101, slt=101010, sll=000000, jr=001000.
  - state encoding: IF, ID, EX, MEM, WB, HALT.
  - ALU control codes.
- Sub-module mc_cpu_ctrl:
  - the FSM plus decode.
  - Outputs the state, register-write enable/select, ALU control and memory strobes.
- The datapath (registers, ALU, muxes) stays in multi_cycle_cpu.

Test Plan:
- Reset/fetch:
  - Stimulus: hold rst_i=0 with RESET_PC=0x40, then release.
  - Required: during reset mem_req_o=0, pc_o=0x40; first cycle after release mem_req_o=1, mem_addr_o=0x40.
- Wait states:
  - Stimulus: addi $1,$0,5 with mem_ready_i delayed 3 cycles in IF.
  - Required: IF lasts 4 cycles, total 7 cycles; $1=5; pc_o=0x44 afterwards.
- Load/store:
  - Stimulus: sw $1,8($0) then lw $2,8($0), zero-wait memory.
  - Required: write at address 8 with data 5; $2=5; sw takes 4 cycles, lw takes 5.
- Branch/jump:
  - Stimulus: beq $1,$1,+2 at 0x0C, then jal to 0x100, then jr $31.
  - Required: PC goes 0x0C -> 0x18 -> 0x100; $31=0x1C; after jr, PC=0x1C.
- Illegal opcode:
  - Stimulus: fetch 0xFC000000.
  - Required: halt_o=1 two edges after fetch accept; mem_req_o stays 0; rst_i low clears halt_o.
- Mid-transfer reset:
  - Stimulus: drop rst_i while in MEM of an sw with mem_ready_i=0.
  - Required: mem_req_o falls immediately, with no register or memory write; restart at RESET_PC.
